imem_loader: RTL and testbench

//   Boot-time writer for the instruction memory that the IF stage reads. Accepts a

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream and instruction-memory write bus for imem_loader.
//   master : stream source / system side (drives start, byte_valid, byte_data)
//   slave  : the loader (drives byte_ready, imem_*, core_hold, done, err)
interface imem_loader_if;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        done;
   logic        err;

   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err
   );

   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction-memory writer.
//   Consumes a byte stream: 16-bit little-endian word count, the words
//   (little-endian bytes), then one XOR checksum byte over the data bytes.
//   Each assembled word is written to BASE_ADDR + 4*word_idx. The core is held
//   (core_hold=1) until a load finishes with a matching checksum.
// Ports:
//   i_clk    : clock, all state on rising edge
//   i_reset  : asynchronous reset, active low
//   bus      : imem_loader_if.slave
//              start/byte_valid/byte_data in; byte_ready, imem_we/addr/wdata,
//              core_hold, done, err out (all registered)
module imem_loader #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic          i_clk,
   input  logic          i_reset,
   imem_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   // Capacity in words; a header larger than this is rejected.
   localparam logic [16:0] CAP = 17'(2**ADDR_W);

   state_t            r_state;
   logic [15:0]       r_len;
   logic [7:0]        r_csum;
   logic [ADDR_W:0]   r_word_idx;   // one extra bit: can reach 2**ADDR_W
   logic [1:0]        r_bcnt;
   logic [23:0]       r_word;       // first three bytes of the word in flight
   logic              r_byte_ready;
   logic              r_imem_we;
   logic [31:0]       r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_core_hold;
   logic              r_done;
   logic              r_err;

   logic              w_take;
   logic [15:0]       w_len_full;
   logic [ADDR_W:0]   w_idx_nxt;
   logic              w_last;
   logic [31:0]       w_addr;

   assign w_take     = bus.byte_valid & r_byte_ready;
   assign w_len_full = {bus.byte_data, r_len[7:0]};
   assign w_idx_nxt  = r_word_idx + (ADDR_W+1)'(1);
   assign w_last     = (32'(w_idx_nxt) == 32'(r_len));
   assign w_addr     = BASE_ADDR + (32'(r_word_idx) << 2);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_csum       <= '0;
         r_word_idx   <= '0;
         r_bcnt       <= '0;
         r_word       <= '0;
         r_byte_ready <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_core_hold  <= 1'b1;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         // Write strobe is a single-cycle pulse, only re-armed from DATA.
         r_imem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.start) begin
                  r_state      <= S_LEN0;
                  r_byte_ready <= 1'b1;
                  r_core_hold  <= 1'b1;
                  r_done       <= 1'b0;
                  r_err        <= 1'b0;
                  r_len        <= '0;
                  r_csum       <= '0;
                  r_word_idx   <= '0;
                  r_bcnt       <= '0;
               end
            end
            S_LEN0: begin
               if (w_take) begin
                  r_len[7:0] <= bus.byte_data;
                  r_state    <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (w_take) begin
                  r_len[15:8] <= bus.byte_data;
                  if ({1'b0, w_len_full} > CAP) begin
                     r_state      <= S_ERR;
                     r_byte_ready <= 1'b0;
                     r_err        <= 1'b1;
                  end else if (w_len_full == 16'd0) begin
                     r_state <= S_CSUM;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_take) begin
                  r_csum <= r_csum ^ bus.byte_data;
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     // Fourth byte goes straight into the top lane of the write.
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= w_addr;
                     r_imem_wdata <= {bus.byte_data, r_word};
                     r_byte_ready <= 1'b0;
                     r_state      <= S_WRITE;
                  end else begin
                     r_word[{r_bcnt, 3'b000} +: 8] <= bus.byte_data;
                  end
               end
            end
            S_WRITE: begin
               r_word_idx   <= w_idx_nxt;
               r_byte_ready <= 1'b1;
               r_state      <= w_last ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
               if (w_take) begin
                  r_byte_ready <= 1'b0;
                  if (bus.byte_data == r_csum) begin
                     r_state     <= S_DONE;
                     r_done      <= 1'b1;
                     r_core_hold <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.byte_ready = r_byte_ready;
   assign bus.imem_we    = r_imem_we;
   assign bus.imem_addr  = r_imem_addr;
   assign bus.imem_wdata = r_imem_wdata;
   assign bus.core_hold  = r_core_hold;
   assign bus.done       = r_done;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int CAPW = 1024;   // 2**ADDR_W words with ADDR_W=10

   logic clk;
   logic rst_n;
   imem_loader_if bus();

   imem_loader #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0]  stim[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   logic        exp_done;
   logic        exp_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, req, $time);
   endtask

   // Stream-level model: derive the writes and the outcome straight from the
   // byte format (header, little-endian words, XOR of data bytes).
   task automatic model_load();
      int          len;
      logic [7:0]  cs;
      logic [31:0] w;
      exp_addr.delete();
      exp_data.delete();
      len = int'(stim[0]) + 256 * int'(stim[1]);
      if (len > CAPW) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
         return;
      end
      cs = 8'h00;
      for (int k = 0; k < len; k++) begin
         w = 32'h0;
         for (int b = 0; b < 4; b++) begin
            w  = w + (32'(stim[2 + 4*k + b]) << (8*b));
            cs = cs ^ stim[2 + 4*k + b];
         end
         exp_addr.push_back(32'(4*k));
         exp_data.push_back(w);
      end
      exp_done = (stim[2 + 4*len] == cs);
      exp_err  = !exp_done;
   endtask

   // Per-cycle compare: every write must match the next expected write, the
   // loader must not accept bytes while writing, and hold is the inverse of done.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("hold_vs_done", 32'(bus.core_hold), 32'(!bus.done));
         if (bus.imem_we) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
            chk("ready_in_write", 32'(bus.byte_ready), 32'h0);
            if (exp_addr.size() == 0) begin
               chk("unexpected_we", 32'h1, 32'h0);
            end else begin
               chk("we_addr", bus.imem_addr, exp_addr.pop_front());
               chk("we_data", bus.imem_wdata, exp_data.pop_front());
            end
         end
      end
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Entered and left on a negedge; byte is taken at the posedge in between.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      n = 0;
      while (!bus.byte_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("byte_timeout", 32'h1, 32'h0);
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic run_load(input int gapmax, input int mid_start);
      int len;
      len = int'(stim[0]) + 256 * int'(stim[1]);
      got_addr.delete();
      got_data.delete();
      model_load();
      pulse_start();
      chk("hold_on_start", 32'(bus.core_hold), 32'h1);
      for (int i = 0; i < stim.size(); i++) begin
         if (i == mid_start) pulse_start();
         send_byte(stim[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
         if (len > 0 && len <= CAPW && i == 1 + 4*len)
            chk("latency_we", 32'(bus.imem_we), 32'h1);
      end
      @(negedge clk);
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("core_hold", 32'(bus.core_hold), 32'(!exp_done));
      chk("writes_pending", 32'(exp_addr.size()), 32'h0);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_hold", 32'(bus.core_hold), 32'h1);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      chk("rst_we", 32'(bus.imem_we), 32'h0);
      chk("rst_ready", 32'(bus.byte_ready), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: reset in the middle of DATA aborts; nothing loads without a new start
      exp_addr.delete();
      exp_data.delete();
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_hold", 32'(bus.core_hold), 32'h1);
      chk("abort_done", 32'(bus.done), 32'h0);
      chk("abort_err", 32'(bus.err), 32'h0);
      chk("abort_we", 32'(bus.imem_we), 32'h0);
      chk("abort_ready", 32'(bus.byte_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h00;
      repeat (5) begin
         @(negedge clk);
         chk("idle_ready", 32'(bus.byte_ready), 32'h0);
      end
      bus.byte_valid = 1'b0;

      // 2: two-word load, good checksum (0x13 ^ 0x93 ^ 0x10 = 0x90)
      stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      run_load(0, -1);
      chk("s2_cnt", 32'(got_data.size()), 32'd2);
      if (got_data.size() == 2) begin
         chk("s2_a0", got_addr[0], 32'h0);
         chk("s2_d0", got_data[0], 32'h00000013);
         chk("s2_a1", got_addr[1], 32'h4);
         chk("s2_d1", got_data[1], 32'h00100093);
      end
      chk("s2_done", 32'(bus.done), 32'h1);

      // 3: same words, bad checksum
      stim[10] = 8'h81;
      run_load(0, -1);
      chk("s3_cnt", 32'(got_data.size()), 32'd2);
      chk("s3_err", 32'(bus.err), 32'h1);
      chk("s3_hold", 32'(bus.core_hold), 32'h1);

      // 4a: empty image
      stim = '{8'h00, 8'h00, 8'h00};
      run_load(0, -1);
      chk("s4a_cnt", 32'(got_data.size()), 32'd0);
      chk("s4a_done", 32'(bus.done), 32'h1);

      // 4b: 1025 words exceeds capacity -> error right after the header
      stim = '{8'h01, 8'h04};
      run_load(0, -1);
      chk("s4b_err", 32'(bus.err), 32'h1);
      chk("s4b_cnt", 32'(got_data.size()), 32'd0);
      chk("s4b_ready", 32'(bus.byte_ready), 32'h0);

      // 5: scenario 2 with random byte_valid gaps
      stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      run_load(3, -1);
      chk("s5_cnt", 32'(got_data.size()), 32'd2);
      if (got_data.size() == 2) chk("s5_d1", got_data[1], 32'h00100093);

      // 6: reload from DONE, with a start pulse in DATA that must be ignored
      stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      run_load(0, 4);
      chk("s6a_done", 32'(bus.done), 32'h1);
      stim = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h83};
      run_load(0, -1);
      chk("s6b_cnt", 32'(got_data.size()), 32'd1);
      if (got_data.size() == 1) begin
         chk("s6b_a0", got_addr[0], 32'h0);
         chk("s6b_d0", got_data[0], 32'h00100093);
      end
      chk("s6b_done", 32'(bus.done), 32'h1);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
